// File: rtl/sw_result_collector.sv
// Reduces the per-target Smith-Waterman score stream to one summary record per query
// (best score, its index, target count, hit count) and queues records for the host.
module sw_result_collector #(
    parameter int CALC_BIT = 16,
    parameter int CNT_BIT  = 16,
    parameter int QID_BIT  = 8,
    parameter int DEPTH    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear_i,
    input  logic [CALC_BIT-1:0]       threshold_i,
    input  logic [CALC_BIT-1:0]       result_i,
    input  logic                      valid_i,
    input  logic                      change_q_i,
    input  logic                      busy_i,
    output logic                      rec_valid_o,
    input  logic                      rec_ready_i,
    output logic [QID_BIT-1:0]        rec_qid_o,
    output logic [CALC_BIT-1:0]       rec_best_o,
    output logic [CNT_BIT-1:0]        rec_best_idx_o,
    output logic [CNT_BIT-1:0]        rec_count_o,
    output logic [CNT_BIT-1:0]        rec_hits_o,
    output logic [$clog2(DEPTH):0]    fill_o,
    output logic                      overflow_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = QID_BIT + CALC_BIT + 3 * CNT_BIT;
    localparam logic [CNT_BIT-1:0] CNT_MAX   = '1;
    localparam logic [AW:0]        FULL_FILL = (AW + 1)'(DEPTH);

    // Running per-query state
    logic [CALC_BIT-1:0] best_q, best_d;
    logic [CNT_BIT-1:0]  best_idx_q, best_idx_d;
    logic [CNT_BIT-1:0]  cnt_q, cnt_d;
    logic [CNT_BIT-1:0]  hits_q, hits_d;
    logic [QID_BIT-1:0]  qid_q;
    logic                busy_q;
    logic                close;

    // FIFO state
    logic [REC_W-1:0]    mem_q [DEPTH];
    logic [AW:0]         wr_ptr_q, rd_ptr_q;
    logic                overflow_q;
    logic [AW:0]         fill;
    logic                full, pop, wr_en, drop;
    logic [REC_W-1:0]    push_rec, head_rec;

    // Running values with this cycle's beat folded in; these are both the
    // next running state and the record contents when the query closes.
    always_comb begin
        best_d     = best_q;
        best_idx_d = best_idx_q;
        cnt_d      = cnt_q;
        hits_d     = hits_q;
        if (valid_i) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (result_i > best_q) begin
                best_d     = result_i;
                best_idx_d = cnt_q;
            end
            if ((result_i >= threshold_i) && (hits_q != CNT_MAX)) begin
                hits_d = hits_q + 1'b1;
            end
        end
    end

    // The busy-edge close counts a beat arriving in the same cycle as the fall.
    assign close    = change_q_i | (busy_q & ~busy_i & (cnt_d != '0));
    assign push_rec = {qid_q, best_d, best_idx_d, cnt_d, hits_d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_q     <= '0;
            best_idx_q <= '0;
            cnt_q      <= '0;
            hits_q     <= '0;
            qid_q      <= '0;
            busy_q     <= 1'b0;
        end else begin
            busy_q <= busy_i;
            if (clear_i) begin
                best_q     <= '0;
                best_idx_q <= '0;
                cnt_q      <= '0;
                hits_q     <= '0;
                qid_q      <= '0;
            end else if (close) begin
                best_q     <= '0;
                best_idx_q <= '0;
                cnt_q      <= '0;
                hits_q     <= '0;
                qid_q      <= qid_q + 1'b1;
            end else begin
                best_q     <= best_d;
                best_idx_q <= best_idx_d;
                cnt_q      <= cnt_d;
                hits_q     <= hits_d;
            end
        end
    end

    // Record handshake: rec_valid_o high means the head record is on rec_*;
    // it is consumed on a rising edge where rec_valid_o & rec_ready_i, and the
    // rec_* outputs hold steady while rec_valid_o & ~rec_ready_i.
    assign fill        = wr_ptr_q - rd_ptr_q;
    assign full        = (fill == FULL_FILL);
    assign rec_valid_o = (fill != '0);
    assign pop         = rec_valid_o & rec_ready_i & ~clear_i;
    assign wr_en       = close & ~clear_i & (~full | pop);
    assign drop        = close & ~clear_i & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_rec;
                wr_ptr_q                <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign head_rec       = mem_q[rd_ptr_q[AW-1:0]];
    assign rec_qid_o      = head_rec[REC_W-1 -: QID_BIT];
    assign rec_best_o     = head_rec[3*CNT_BIT +: CALC_BIT];
    assign rec_best_idx_o = head_rec[2*CNT_BIT +: CNT_BIT];
    assign rec_count_o    = head_rec[CNT_BIT +: CNT_BIT];
    assign rec_hits_o     = head_rec[0 +: CNT_BIT];
    assign fill_o         = fill;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_sw_result_collector.sv
// Directed and short random stimulus for sw_result_collector, checked every cycle
// against a query/record model built from beat lists and a record queue.
module tb_sw_result_collector;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_i = 1'b0;
  logic [15:0] threshold_i = 16'd6;
  logic [15:0] result_i = '0;
  logic        valid_i = 1'b0;
  logic        change_q_i = 1'b0;
  logic        busy_i = 1'b0;
  logic        rec_valid_o;
  logic        rec_ready_i = 1'b0;
  logic [7:0]  rec_qid_o;
  logic [15:0] rec_best_o;
  logic [15:0] rec_best_idx_o;
  logic [15:0] rec_count_o;
  logic [15:0] rec_hits_o;
  logic [2:0]  fill_o;
  logic        overflow_o;

  int checks = 0;
  int failures = 0;

  sw_result_collector #(.CALC_BIT(16), .CNT_BIT(16), .QID_BIT(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .threshold_i(threshold_i),
    .result_i(result_i), .valid_i(valid_i), .change_q_i(change_q_i), .busy_i(busy_i),
    .rec_valid_o(rec_valid_o), .rec_ready_i(rec_ready_i), .rec_qid_o(rec_qid_o),
    .rec_best_o(rec_best_o), .rec_best_idx_o(rec_best_idx_o), .rec_count_o(rec_count_o),
    .rec_hits_o(rec_hits_o), .fill_o(fill_o), .overflow_o(overflow_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // model: current query beats, record queue, qid, overflow
  typedef struct {
    int qid;
    int best;
    int idx;
    int cnt;
    int hits;
  } rec_t;

  int   beats_m[$];
  bit   hit_m[$];
  rec_t fifo_m[$];
  int   qid_m = 0;
  bit   ovf_m = 0;
  bit   busy_prev_m = 0;

  function automatic rec_t summarize();
    rec_t r;
    r.qid  = qid_m;
    r.best = 0;
    r.idx  = 0;
    r.cnt  = beats_m.size();
    r.hits = 0;
    foreach (beats_m[i]) begin
      if (beats_m[i] > r.best) begin
        r.best = beats_m[i];
        r.idx  = i;
      end
      if (hit_m[i]) r.hits++;
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beats_m.delete();
      hit_m.delete();
      fifo_m.delete();
      qid_m = 0;
      ovf_m = 0;
      busy_prev_m = 0;
    end else begin
      if (clear_i) begin
        beats_m.delete();
        hit_m.delete();
        fifo_m.delete();
        qid_m = 0;
        ovf_m = 0;
      end else begin
        bit   closing;
        bit   popping;
        rec_t r;
        if (valid_i) begin
          beats_m.push_back(int'(result_i));
          hit_m.push_back(result_i >= threshold_i);
        end
        closing = change_q_i || (busy_prev_m && !busy_i && beats_m.size() != 0);
        popping = (fifo_m.size() > 0) && rec_ready_i;
        if (popping) void'(fifo_m.pop_front());
        if (closing) begin
          r = summarize();
          qid_m = (qid_m + 1) % 256;
          beats_m.delete();
          hit_m.delete();
          if (fifo_m.size() < 4) fifo_m.push_back(r);
          else ovf_m = 1;
        end
      end
      busy_prev_m = busy_i;
    end
  end

  // scoreboard: compare against the model every cycle outside reset
  always @(negedge clk) begin
    if (rst_n) begin
      chk("rec_valid", rec_valid_o, fifo_m.size() > 0);
      chk("fill", fill_o, fifo_m.size());
      chk("overflow", overflow_o, ovf_m);
      if (fifo_m.size() > 0) begin
        chk("head_qid", rec_qid_o, fifo_m[0].qid);
        chk("head_best", rec_best_o, fifo_m[0].best);
        chk("head_idx", rec_best_idx_o, fifo_m[0].idx);
        chk("head_count", rec_count_o, fifo_m[0].cnt);
        chk("head_hits", rec_hits_o, fifo_m[0].hits);
      end
    end
  end

  // driver: apply one cycle of stimulus starting at a falling edge
  task automatic step(input bit v, input int r, input bit ch, input bit rdy);
    valid_i = v;
    result_i = 16'(r);
    change_q_i = ch;
    rec_ready_i = rdy;
    @(negedge clk);
    valid_i = 1'b0;
    change_q_i = 1'b0;
    rec_ready_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit drained;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", rec_valid_o, 0);
    chk("rst_fill", fill_o, 0);
    chk("rst_overflow", overflow_o, 0);
    chk("rst_qid", rec_qid_o, 0);
    chk("rst_best", rec_best_o, 0);
    chk("rst_count", rec_count_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // single query: 5, 9, 9, 3 with threshold 6
    threshold_i = 16'd6;
    step(1, 5, 0, 0);
    step(1, 9, 0, 0);
    step(1, 9, 0, 0);
    step(1, 3, 0, 0);
    chk("sq_valid_before", rec_valid_o, 0);
    step(0, 0, 1, 0);
    chk("sq_valid", rec_valid_o, 1);
    chk("sq_qid", rec_qid_o, 0);
    chk("sq_best", rec_best_o, 9);
    chk("sq_idx", rec_best_idx_o, 1);
    chk("sq_count", rec_count_o, 4);
    chk("sq_hits", rec_hits_o, 2);
    step(0, 0, 0, 1);
    chk("sq_popped", rec_valid_o, 0);

    // beat coincident with close, then a fresh query
    step(1, 2, 0, 0);
    step(1, 7, 1, 0);
    chk("co_qid", rec_qid_o, 1);
    chk("co_best", rec_best_o, 7);
    chk("co_idx", rec_best_idx_o, 1);
    chk("co_count", rec_count_o, 2);
    step(0, 0, 0, 1);
    step(1, 4, 1, 0);
    chk("nx_qid", rec_qid_o, 2);
    chk("nx_best", rec_best_o, 4);
    chk("nx_idx", rec_best_idx_o, 0);
    chk("nx_count", rec_count_o, 1);
    step(0, 0, 0, 1);

    // end of job by busy falling edge
    busy_i = 1'b1;
    step(1, 3, 0, 0);
    step(1, 8, 0, 0);
    busy_i = 1'b0;
    step(0, 0, 0, 0);
    chk("busy_valid", rec_valid_o, 1);
    chk("busy_qid", rec_qid_o, 3);
    chk("busy_count", rec_count_o, 2);
    step(0, 0, 0, 1);
    busy_i = 1'b1;
    step(0, 0, 0, 0);
    busy_i = 1'b0;
    step(0, 0, 0, 0);
    chk("busy_empty_fill", fill_o, 0);

    // overflow: 5 closes with no host reads
    do_clear();
    for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
    chk("ov_fill", fill_o, 4);
    chk("ov_flag", overflow_o, 1);
    for (int i = 0; i < 3; i++) begin
      chk("ov_qid", rec_qid_o, i);
      step(0, 0, 0, 1);
    end
    chk("ov_last_qid", rec_qid_o, 3);
    do_clear();
    chk("clr_fill", fill_o, 0);
    chk("clr_overflow", overflow_o, 0);

    // back-pressure: full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0);
    chk("bp_full", fill_o, 4);
    step(1, 11, 1, 1);
    chk("bp_fill", fill_o, 4);
    chk("bp_overflow", overflow_o, 0);
    chk("bp_head", rec_qid_o, 1);

    // random ready toggling with mixed traffic, then drain
    drained = 0;
    for (int i = 0; i < 400; i++) begin
      threshold_i = 16'($urandom_range(0, 15));
      if (i < 60)
        step($urandom_range(0, 1), $urandom_range(0, 20), $urandom_range(0, 5) == 0,
             $urandom_range(0, 1));
      else
        step(0, 0, 0, $urandom_range(0, 1));
      if (i >= 60 && fifo_m.size() == 0) begin
        drained = 1;
        break;
      end
    end
    chk("rand_drained", drained, 1);
    chk("rand_fill", fill_o, 0);

    // asynchronous reset mid-query with a record pending
    threshold_i = 16'd6;
    step(1, 3, 0, 0);
    step(0, 0, 1, 0);
    step(1, 4, 0, 0);
    chk("ar_pending", rec_valid_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", rec_valid_o, 0);
    chk("ar_fill", fill_o, 0);
    chk("ar_overflow", overflow_o, 0);
    chk("ar_qid", rec_qid_o, 0);
    chk("ar_best", rec_best_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    step(1, 5, 1, 0);
    chk("ar_next_qid", rec_qid_o, 0);
    chk("ar_next_count", rec_count_o, 1);
    chk("ar_next_best", rec_best_o, 5);
    step(0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
